bus_arbiter: RTL and testbench

- Round-robin arbiter for the 4-master shared bus.
- Drives the one-hot m0..m3_grnt that select which master's addr/as/rw/wr_data reach the slave side through the bus master multiplexer.
- Grants are registered and held while the owner keeps requesting.
- A programmable hold limit forces rotation so no master can starve the others.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arb_rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and index helpers for the 4-master bus arbiter.
package bus_arbiter_pkg;

    localparam logic ENABLE       = 1'b1;
    localparam logic DISABLE      = 1'b0;
    localparam int   MASTER_W     = 2;
    localparam int   NUM_MASTERS  = 4;
    localparam int   BUS_ARB_ST_W = 1;

    typedef logic [MASTER_W-1:0] master_idx_t;

    typedef enum logic [BUS_ARB_ST_W-1:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_arb_state_e;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input master_idx_t idx);
        return NUM_MASTERS'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin search: first request at start, start+1, ... (mod 4)
// that is not masked out by excl.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  master_idx_t            start,
    input  logic [NUM_MASTERS-1:0] excl,
    output logic                   found,
    output master_idx_t            idx
);

    master_idx_t cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = start + master_idx_t'(i);
            if (!found && req[cand] && !excl[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 4-master shared bus with registered one-hot grants
// and a hold limit that forces rotation when another master is waiting.
//
// state   | meaning
// ST_IDLE | no grant asserted, waiting for any request
// ST_BUSY | one master owns the bus, grant held while it requests
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m3_req,
    output logic       m0_grnt,
    output logic       m1_grnt,
    output logic       m2_grnt,
    output logic       m3_grnt,
    output logic [1:0] owner,
    output logic       busy
);

    bus_arb_state_e           state, state_nxt;
    logic [NUM_MASTERS-1:0]   grnt, grnt_nxt;
    master_idx_t              owner_q, owner_nxt;
    master_idx_t              last_owner, last_owner_nxt;
    logic [HOLD_W-1:0]        hold_cnt, hold_cnt_nxt;

    logic [NUM_MASTERS-1:0]   req_v;
    logic                     pick_found;
    master_idx_t              pick_idx;
    logic                     own_req;
    logic                     hold_hit;

    assign req_v = {m3_req, m2_req, m1_req, m0_req};

    // Excluding the current grant makes one search serve all cases: in IDLE grnt
    // is zero, on release the owner is not requesting, on rotation it must lose.
    bus_arb_rr_pick u_rr_pick (
        .req   (req_v),
        .start (last_owner + master_idx_t'(1)),
        .excl  (grnt),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_req  = req_v[owner_q];
    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_nxt      = state;
        grnt_nxt       = grnt;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;

        unique case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt      = ST_BUSY;
                    grnt_nxt       = idx_to_onehot(pick_idx);
                    owner_nxt      = pick_idx;
                    last_owner_nxt = pick_idx;
                    hold_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (own_req && !(hold_hit && pick_found)) begin
                    // Parking at the limit keeps rotation armed for the next waiter.
                    if (!hold_hit && hold_cnt != '1)
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end else if (pick_found) begin
                    grnt_nxt       = idx_to_onehot(pick_idx);
                    owner_nxt      = pick_idx;
                    last_owner_nxt = pick_idx;
                    hold_cnt_nxt   = '0;
                end else begin
                    state_nxt    = ST_IDLE;
                    grnt_nxt     = '0;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grnt       <= '0;
            owner_q    <= '0;
            last_owner <= master_idx_t'(NUM_MASTERS - 1);
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grnt       <= grnt_nxt;
            owner_q    <= owner_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    assign m0_grnt = grnt[0];
    assign m1_grnt = grnt[1];
    assign m2_grnt = grnt[2];
    assign m3_grnt = grnt[3];
    assign owner   = owner_q;
    assign busy    = (grnt != '0) ? ENABLE : DISABLE;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter: a MAX_HOLD=16 instance and an unlimited
// (MAX_HOLD=0) instance share clock and reset.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_u;
    logic [3:0] grnt;
    logic [3:0] grnt_u;
    logic [1:0] owner;
    logic [1:0] owner_u;
    logic       busy;
    logic       busy_u;

    int n_vec = 0;
    int n_err = 0;

    bus_arbiter #(.MAX_HOLD(16), .HOLD_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_req  (req[0]),
        .m1_req  (req[1]),
        .m2_req  (req[2]),
        .m3_req  (req[3]),
        .m0_grnt (grnt[0]),
        .m1_grnt (grnt[1]),
        .m2_grnt (grnt[2]),
        .m3_grnt (grnt[3]),
        .owner   (owner),
        .busy    (busy)
    );

    bus_arbiter #(.MAX_HOLD(0), .HOLD_W(8)) dut_nolim (
        .clk     (clk),
        .reset   (reset),
        .m0_req  (req_u[0]),
        .m1_req  (req_u[1]),
        .m2_req  (req_u[2]),
        .m3_req  (req_u[3]),
        .m0_grnt (grnt_u[0]),
        .m1_grnt (grnt_u[1]),
        .m2_grnt (grnt_u[2]),
        .m3_grnt (grnt_u[3]),
        .owner   (owner_u),
        .busy    (busy_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int good;
        int bad;
        int rot_at;

        reset = 1'b1;
        req   = 4'b0000;
        req_u = 4'b0000;
        tick();
        tick();
        check_val("rst_grnt", int'(grnt), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_owner", int'(owner), 0);
        check_val("rst_grnt_u", int'(grnt_u), 0);

        // Post-reset priority and release order
        reset = 1'b0;
        req = 4'b1111;
        tick();
        check_val("all_req_grnt", int'(grnt), 4'b0001);
        check_val("all_req_owner", int'(owner), 0);
        check_val("all_req_busy", int'(busy), 1);
        req = 4'b1110;
        tick();
        check_val("drop_m0_grnt", int'(grnt), 4'b0010);
        check_val("drop_m0_owner", int'(owner), 1);
        req = 4'b1100;
        tick();
        check_val("drop_m1_grnt", int'(grnt), 4'b0100);
        req = 4'b1000;
        tick();
        check_val("drop_m2_grnt", int'(grnt), 4'b1000);
        check_val("drop_m2_owner", int'(owner), 3);
        req = 4'b0000;
        tick();
        check_val("all_drop_busy", int'(busy), 0);

        // Lone master holds well past the limit
        req = 4'b0100;
        good = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grnt == 4'b0100) good++;
        end
        check_val("m2_hold_cycles", good, 40);
        // Limit stays armed: a newcomer takes over at the next edge
        req = 4'b0101;
        tick();
        check_val("armed_rotate", int'(grnt), 4'b0001);
        req = 4'b0000;
        tick();
        check_val("hold_release_busy", int'(busy), 0);

        // Forced rotation: m1 owns, m3 arrives at grant cycle 5
        req = 4'b0010;
        rot_at = -1;
        bad = 0;
        for (int k = 1; k <= 40 && rot_at < 0; k++) begin
            tick();
            if (!$onehot0(grnt)) bad++;
            if (k == 5) req = 4'b1010;
            if (grnt[3]) begin
                rot_at = k - 1;
                check_val("rot_grnt", int'(grnt), 4'b1000);
            end
        end
        check_val("rot_latency", rot_at, 16);
        check_val("rot_onehot", bad, 0);
        req = 4'b0000;
        tick();
        tick();
        check_val("rot_idle", int'(busy), 0);

        // Direct handover with no idle cycle
        req = 4'b0001;
        tick();
        tick();
        check_val("ho_m0_grnt", int'(grnt), 4'b0001);
        req = 4'b0100;
        tick();
        check_val("ho_grnt", int'(grnt), 4'b0100);
        check_val("ho_owner", int'(owner), 2);
        req = 4'b0000;
        tick();

        // Reset mid-ownership
        req = 4'b1000;
        tick();
        check_val("pre_rst_grnt", int'(grnt), 4'b1000);
        reset = 1'b1;
        tick();
        check_val("mid_rst_grnt", int'(grnt), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        req = 4'b1001;
        tick();
        check_val("post_rst_grnt", int'(grnt), 4'b0001);
        check_val("post_rst_owner", int'(owner), 0);
        req = 4'b0000;
        tick();

        // Unlimited hold: m1 waits until m0 lets go
        req_u = 4'b0001;
        tick();
        check_val("nolim_m0", int'(grnt_u), 4'b0001);
        req_u = 4'b0011;
        good = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grnt_u == 4'b0001) good++;
        end
        check_val("nolim_hold_cycles", good, 100);
        req_u = 4'b0010;
        tick();
        check_val("nolim_m1_grnt", int'(grnt_u), 4'b0010);
        check_val("nolim_m1_owner", int'(owner_u), 1);
        req_u = 4'b0000;
        tick();
        check_val("nolim_idle", int'(busy_u), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
